// File: rtl/store_pkg.sv
// store_pkg: shared store-select encodings and FIFO entry payload for store_write_buffer.
`default_nettype none

package store_pkg;

  localparam logic [1:0] SSEL_W   = 2'b00;
  localparam logic [1:0] SSEL_B   = 2'b01;
  localparam logic [1:0] SSEL_H   = 2'b10;
  localparam logic [1:0] SSEL_ILL = 2'b11;

  // Word address lives in its own array beside this payload since its width is a parameter.
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
  } store_entry_t;

endpackage

`default_nettype wire

// File: rtl/store_fmt.sv
// store_fmt: turns a sw/sh/sb request into byte enables, lane-replicated data and a reject flag.
// STORE_ALIGN_CHK_EN adds misalignment rejection for sh/sw.
`default_nettype none

module store_fmt
  import store_pkg::*;
(
  input  logic [1:0]  ssel,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        reject
);

  always_comb begin
    be     = 4'b0000;
    wdata  = data;
    reject = 1'b0;
    case (ssel)
      SSEL_W: begin
        be    = 4'b1111;
        wdata = data;
`ifdef STORE_ALIGN_CHK_EN
        reject = (addr_lo != 2'b00);
`endif
      end
      SSEL_H: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data[15:0]}};
`ifdef STORE_ALIGN_CHK_EN
        reject = addr_lo[0];
`endif
      end
      SSEL_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      SSEL_ILL: begin
        reject = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/store_write_buffer.sv
// store_write_buffer: queues formatted stores and drains them in order over a valid/ready port.
// Optional STORE_ALIGN_CHK_EN drops misaligned/illegal stores and pulses st_exc.
`default_nettype none

module store_write_buffer
  import store_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [1:0]    SSel_M,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          mem_wvalid,
  input  logic          mem_wready,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit,
  output logic          st_exc,
  output logic          buf_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr, head;
  logic [CW-1:0] count;
  logic [AW-3:0] addr_mem [DEPTH];
  store_entry_t  ent_mem  [DEPTH];

  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic        fmt_reject;
  logic        accept, push, pop;

  store_fmt u_fmt (
    .ssel    (SSel_M),
    .addr_lo (st_addr[1:0]),
    .data    (st_data),
    .be      (fmt_be),
    .wdata   (fmt_wdata),
    .reject  (fmt_reject)
  );

  assign st_ready   = (count != CW'(DEPTH));
  assign mem_wvalid = (count != '0);
  assign buf_empty  = (count == '0);
  assign accept     = st_valid && st_ready;
  assign push       = accept && !fmt_reject;
  assign pop        = mem_wvalid && mem_wready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= st_addr[AW-1:2];
      ent_mem[wr_ptr]  <= '{data: fmt_wdata, be: fmt_be};
    end
  end

  // When empty, point at the slot just drained so the port holds the last head.
  assign head      = buf_empty ? (rd_ptr - PW'(1)) : rd_ptr;
  assign mem_addr  = {addr_mem[head], 2'b00};
  assign mem_wdata = ent_mem[head].data;
  assign mem_be    = ent_mem[head].be;

  always_comb begin : ld_match
    logic [PW-1:0] off;
    ld_hit = 1'b0;
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (({1'b0, off} < count) && (addr_mem[i] == ld_addr[AW-1:2])) ld_hit = 1'b1;
    end
  end

  logic unused_ld_lo;
  assign unused_ld_lo = ^ld_addr[1:0];

`ifdef STORE_ALIGN_CHK_EN
  logic exc_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) exc_q <= 1'b0;
    else       exc_q <= accept && fmt_reject;
  end
  assign st_exc = exc_q;
`else
  assign st_exc = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: randomized + directed scoreboard bench for store_write_buffer.
`default_nettype none

module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
`ifdef STORE_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          st_valid = 1'b0;
  logic          st_ready;
  logic [1:0]    SSel_M = 2'b00;
  logic [AW-1:0] st_addr = '0;
  logic [31:0]   st_data = '0;
  logic          mem_wvalid;
  logic          mem_wready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [AW-1:0] ld_addr = '0;
  logic          ld_hit;
  logic          st_exc;
  logic          buf_empty;

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .SSel_M     (SSel_M),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .ld_addr    (ld_addr),
    .ld_hit     (ld_hit),
    .st_exc     (st_exc),
    .buf_empty  (buf_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  logic exp_exc = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference formatting from the store rules, using plain arithmetic.
  task automatic model_fmt(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                           output exp_t e, output bit ok);
    int lane;
    lane   = a % 4;
    e.addr = (a / 4) * 4;
    e.data = d;
    e.be   = 4'd0;
    ok     = 1'b1;
    case (s)
      2'd0: begin e.be = 4'd15; e.data = d; if (ALIGN && lane != 0) ok = 1'b0; end
      2'd1: begin e.be = 4'(1 << lane); e.data = (d % 256) * 32'h01010101; end
      2'd2: begin
        e.be   = (lane >= 2) ? 4'd12 : 4'd3;
        e.data = (d % 65536) * 32'h00010001;
        if (ALIGN && (lane % 2) == 1) ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
  endtask

  function automatic bit model_hit(input logic [31:0] la);
    bit h = 1'b0;
    foreach (exp_q[i]) if (exp_q[i].addr / 4 == la / 4) h = 1'b1;
    return h;
  endfunction

  task automatic check_state();
    chk("st_ready", st_ready, (exp_q.size() < DEPTH));
    chk("mem_wvalid", mem_wvalid, (exp_q.size() != 0));
    chk("buf_empty", buf_empty, (exp_q.size() == 0));
    chk("st_exc", st_exc, exp_exc);
    if (exp_q.size() != 0) begin
      chk("head_addr", mem_addr, exp_q[0].addr);
      chk("head_data", mem_wdata, exp_q[0].data);
      chk("head_be", mem_be, exp_q[0].be);
    end
  endtask

  // One clock: check post-edge state, then drive the inputs for the next edge and predict it.
  task automatic step(input logic v, input logic [1:0] s, input logic [31:0] a,
                      input logic [31:0] d, input logic wr, input logic [31:0] la);
    exp_t e;
    bit   ok;
    @(posedge clk);
    #2;
    check_state();
    st_valid   = v;
    SSel_M     = s;
    st_addr    = a;
    st_data    = d;
    mem_wready = wr;
    ld_addr    = la;
    #1;
    chk("ld_hit", ld_hit, model_hit(la));
    exp_exc = 1'b0;
    if (v && exp_q.size() < DEPTH) begin
      model_fmt(s, a, d, e, ok);
      if (ok) exp_q.push_back(e);
      else    exp_exc = ALIGN;
    end
  endtask

  // Monitor: retire the head on every completed memory handshake.
  always @(negedge clk) begin
    if (!reset && mem_wvalid && mem_wready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_unexpected actual addr=%h required none", mem_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("drain_addr", mem_addr, e.addr);
        chk("drain_data", mem_wdata, e.data);
        chk("drain_be", mem_be, e.be);
      end
    end
  end

  initial begin
    #22;
    chk("rst_st_ready", st_ready, 1'b1);
    chk("rst_wvalid", mem_wvalid, 1'b0);
    chk("rst_empty", buf_empty, 1'b1);
    chk("rst_ld_hit", ld_hit, 1'b0);
    chk("rst_exc", st_exc, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // sb / sh / sw formatting, visible one cycle after accept
    step(1, 2'b01, 32'h1003, 32'h000000AB, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0);
    chk("sb_addr", mem_addr, 32'h1000);
    chk("sb_be", mem_be, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    step(1, 2'b10, 32'h2002, 32'h00001234, 1, 0);
    step(0, 2'b00, 0, 0, 0, 0);
    chk("sh_be", mem_be, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'h12341234);
    step(1, 2'b00, 32'h3000, 32'hDEADBEEF, 1, 0);
    step(0, 2'b00, 0, 0, 1, 0);
    chk("sw_be", mem_be, 4'b1111);
    step(0, 2'b00, 0, 0, 1, 0);

    // fill with memory stalled, fifth held, full + pop same cycle, then drain
    for (int i = 0; i < 5; i++) step(1, 2'b00, 32'h600 + 4 * i, 32'hA0 + i, 0, 0);
    step(1, 2'b00, 32'h614, 32'hA5, 0, 0);
    chk("full_ready", st_ready, 1'b0);
    step(1, 2'b00, 32'h614, 32'hA5, 1, 0);
    step(0, 2'b00, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 2'b00, 0, 0, 1, 0);

    // load overlap detection
    step(1, 2'b00, 32'h4000, 32'h11112222, 0, 0);
    step(0, 2'b00, 0, 0, 0, 32'h4002);
    chk("ld_hit_same_word", ld_hit, 1'b1);
    step(0, 2'b00, 0, 0, 1, 32'h4004);
    chk("ld_hit_next_word", ld_hit, 1'b0);
    step(0, 2'b00, 0, 0, 1, 32'h4000);
    chk("ld_hit_drained", ld_hit, 1'b0);

    // misaligned halfword and illegal select
    step(1, 2'b10, 32'h5001, 32'h0000BEEF, 0, 0);
    step(1, 2'b11, 32'h5004, 32'h12345678, 0, 0);
    step(0, 2'b00, 0, 0, 1, 0);
    step(0, 2'b00, 0, 0, 1, 0);
    step(0, 2'b00, 0, 0, 1, 0);

    // reset with two entries pending
    step(1, 2'b00, 32'h7000, 32'h1, 0, 0);
    step(1, 2'b00, 32'h7004, 32'h2, 0, 0);
    step(0, 2'b00, 0, 0, 0, 32'h7004);
    @(posedge clk);
    #4;
    reset = 1'b1;
    #1;
    chk("rst_mid_wvalid", mem_wvalid, 1'b0);
    chk("rst_mid_empty", buf_empty, 1'b1);
    chk("rst_mid_ld_hit", ld_hit, 1'b0);
    exp_q.delete();
    exp_exc = 1'b0;
    #12;
    @(negedge clk);
    reset = 1'b0;

    // randomized traffic over a small address window so overlaps are frequent
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 2'($urandom % 4), 32'h100 + ($urandom % 16), $urandom,
           ($urandom % 3) != 0, 32'h100 + ($urandom % 20));
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(0, 2'b00, 0, 0, 1, 0);
    step(0, 2'b00, 0, 0, 0, 0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain actual pending=%0d required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
